regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_ctrl_pkg.sv | 24 ++
 rtl/rr_arbiter3.sv | 26 ++
 rtl/regfile_write_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants, FSM state type and small helpers for the register-file write path.
package regfile_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 16;
    localparam int unsigned NREQ   = 3;
    localparam int unsigned ADDR_W = 4;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t ZERO = 1'b1;

    function automatic logic [1:0] wrapIdx(input int unsigned v);
        return 2'(v % NREQ);
    endfunction

    function automatic logic [NREGS-1:0] oneHot(input logic [ADDR_W-1:0] idx);
        logic [NREGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational round-robin pick among three requesters; search starts at ptr.
module rr_arbiter3
    import regfile_ctrl_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] gnt
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = wrapIdx(32'(ptr) + k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates three write requesters onto one register-file write port, with a
// 16-cycle zero-fill sequence that takes priority over normal writes.
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     clr,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    input  logic                     zero_start,
    output logic                     zero_busy,
    output logic [NREGS-1:0]         reg_en,
    output logic [DATA_W-1:0]        reg_data
);

    state_t              state;
    logic [1:0]          ptr;
    logic [ADDR_W-1:0]   cnt;
    logic [NREQ-1:0]     arbGnt;
    logic [ADDR_W-1:0]   selAddr;
    logic [DATA_W-1:0]   selData;
    logic [1:0]          nextPtr;

    rr_arbiter3 uArb (
        .req (req),
        .ptr (ptr),
        .gnt (arbGnt)
    );

    // Grants only in IDLE, only out of reset, and never when a fill is being requested
    always_comb begin
        gnt = '0;
        if (clr && state == IDLE && !zero_start) begin
            gnt = arbGnt;
        end
    end

    always_comb begin
        selAddr = '0;
        selData = '0;
        nextPtr = ptr;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                selAddr = req_addr[ADDR_W*i +: ADDR_W];
                selData = req_data[DATA_W*i +: DATA_W];
                nextPtr = wrapIdx(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            zero_busy <= 1'b0;
            reg_en    <= '0;
            reg_data  <= '0;
        end else begin
            reg_en <= '0;
            case (state)
                IDLE: begin
                    if (zero_start) begin
                        state     <= ZERO;
                        cnt       <= '0;
                        zero_busy <= 1'b1;
                    end else if (|gnt) begin
                        reg_en   <= oneHot(selAddr);
                        reg_data <= selData;
                        ptr      <= nextPtr;
                    end
                end
                ZERO: begin
                    reg_en   <= oneHot(cnt);
                    reg_data <= '0;
                    cnt      <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state     <= IDLE;
                        zero_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
